conv_mac_pipe: RTL and testbench

- Parametrised, pipelined KxK signed convolution processing element.
- Each cycle it accepts one KxK activation window and one KxK weight window through a valid/ready handshake.
- It accumulates the dot products over CH consecutive input channels, then emits one rescaled, optionally ReLU'd, saturated output pixel.
- Sits between the line-buffer/window generator and the output feature-map writer; successor of the fixed 3x3 conv unit.

---
 rtl/conv_mac_pipe.sv | 101 ++++++++++
 tb/tb_conv_mac_pipe.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/conv_mac_pipe.sv
// conv_mac_pipe: pipelined KxK signed conv MAC over CH channels with shift, optional ReLU and saturation
module conv_mac_pipe #(
    parameter int WIDTH = 9,
    parameter int K     = 3,
    parameter int CH    = 4,
    parameter int FRAC  = 0,
    parameter int ACC_W = 2*WIDTH+$clog2(K*K*CH)+1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [K*K*WIDTH-1:0]   act,
    input  logic [K*K*WIDTH-1:0]   wgt,
    input  logic                   relu_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_sat
);
    localparam int N  = K*K;
    localparam int PW = 2*WIDTH;
    localparam int TW = CH > 1 ? $clog2(CH) : 1;
    localparam logic [TW-1:0] LAST = TW'(CH-1);
    localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic                    en;
    logic [TW-1:0]           cnt, s1_tag, s2_tag;
    logic                    s1_valid, s1_relu, s2_valid, s2_relu;
    logic signed [PW-1:0]    prod [N];
    logic signed [ACC_W-1:0] sum, s2_sum, acc, total, shifted, clipped;
    logic                    last2, hi, lo;
    logic [WIDTH-1:0]        next_data;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            s1_valid <= 1'b0;
            s1_tag   <= '0;
            s1_relu  <= 1'b0;
            for (int i = 0; i < N; i++) prod[i] <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_tag   <= cnt;
            s1_relu  <= relu_en;
            for (int i = 0; i < N; i++)
                prod[i] <= PW'($signed(act[i*WIDTH +: WIDTH])) * PW'($signed(wgt[i*WIDTH +: WIDTH]));
            if (in_valid) cnt <= (cnt == LAST) ? '0 : cnt + TW'(1);
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < N; i++) sum = sum + ACC_W'(prod[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_tag   <= '0;
            s2_relu  <= 1'b0;
            s2_sum   <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_tag   <= s1_tag;
            s2_relu  <= s1_relu;
            s2_sum   <= sum;
        end
    end

    // Only the last channel's relu flag matters; earlier ones are dropped here.
    always_comb begin
        last2     = s2_valid && (s2_tag == LAST);
        total     = (CH == 1) ? s2_sum : acc + s2_sum;
        shifted   = total >>> FRAC;
        clipped   = (s2_relu && shifted[ACC_W-1]) ? '0 : shifted;
        hi        = clipped > MAXV;
        lo        = clipped < MINV;
        next_data = hi ? MAXV[WIDTH-1:0] : lo ? MINV[WIDTH-1:0] : clipped[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (en) begin
            out_valid <= last2;
            if (s2_valid) acc <= last2 ? '0 : (s2_tag == '0) ? s2_sum : acc + s2_sum;
            if (last2) begin
                out_data <= next_data;
                out_sat  <= hi || lo;
            end
        end
    end
endmodule

// File: tb/tb_conv_mac_pipe.sv
// tb_conv_mac_pipe: directed checks of a CH=1/FRAC=0 and a CH=4/FRAC=2 instance
module tb_conv_mac_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              a_iv, a_ir, a_relu, a_ov, a_or, a_sat;
    logic [80:0]       a_act, a_wgt;
    logic signed [8:0] a_data;
    logic              b_iv, b_ir, b_relu, b_ov, b_or, b_sat;
    logic [80:0]       b_act, b_wgt;
    logic signed [8:0] b_data;

    int n_cmp = 0;
    int n_err = 0;

    conv_mac_pipe #(.WIDTH(9), .K(3), .CH(1), .FRAC(0)) u1 (
        .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .act(a_act), .wgt(a_wgt),
        .relu_en(a_relu), .out_valid(a_ov), .out_ready(a_or), .out_data(a_data), .out_sat(a_sat)
    );
    conv_mac_pipe #(.WIDTH(9), .K(3), .CH(4), .FRAC(2)) u4 (
        .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .act(b_act), .wgt(b_wgt),
        .relu_en(b_relu), .out_valid(b_ov), .out_ready(b_or), .out_data(b_data), .out_sat(b_sat)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // CH=1 single beat: output three cycles after accept, one-cycle pulse
    task automatic one1(input string tag, input logic [8:0] a, input logic [8:0] w, input logic relu,
                        input logic signed [31:0] ed, input logic es);
        a_iv = 1'b1; a_act = {9{a}}; a_wgt = {9{w}}; a_relu = relu;
        tick();
        a_iv = 1'b0; a_relu = 1'b0;
        chk({tag, "_v0"}, 32'(a_ov), 0);
        tick();
        chk({tag, "_v1"}, 32'(a_ov), 0);
        tick();
        chk({tag, "_v2"}, 32'(a_ov), 1);
        chk({tag, "_data"}, a_data, ed);
        chk({tag, "_sat"}, 32'(a_sat), 32'(es));
        tick();
        chk({tag, "_pulse"}, 32'(a_ov), 0);
    endtask

    // CH=4 group: act all a, wgt all 1..4 on back-to-back beats
    task automatic grp4(input string tag, input logic [8:0] a, input logic [3:0] rm,
                        input logic signed [31:0] ed);
        logic [8:0] w;
        for (int i = 0; i < 4; i++) begin
            w = 9'(i + 1);
            b_iv = 1'b1; b_act = {9{a}}; b_wgt = {9{w}}; b_relu = rm[i];
            tick();
            chk({tag, "_mid"}, 32'(b_ov), 0);
        end
        b_iv = 1'b0; b_relu = 1'b0;
        tick();
        chk({tag, "_v4"}, 32'(b_ov), 0);
        tick();
        chk({tag, "_v5"}, 32'(b_ov), 1);
        chk({tag, "_data"}, b_data, ed);
        chk({tag, "_sat"}, 32'(b_sat), 0);
        tick();
        chk({tag, "_pulse"}, 32'(b_ov), 0);
    endtask

    initial begin
        logic [8:0] w;
        rst = 1'b1;
        a_iv = 1'b0; a_act = '0; a_wgt = '0; a_relu = 1'b0; a_or = 1'b1;
        b_iv = 1'b0; b_act = '0; b_wgt = '0; b_relu = 1'b0; b_or = 1'b1;
        tick();
        tick();
        chk("rst_ov", 32'(a_ov), 0);
        chk("rst_data", a_data, 0);
        chk("rst_sat", 32'(a_sat), 0);
        chk("rst_ov4", 32'(b_ov), 0);
        rst = 1'b0;
        #1;
        chk("rst_ir", 32'(a_ir), 1);
        chk("rst_ir4", 32'(b_ir), 1);

        one1("pos", 9'd1, 9'd2, 1'b0, 18, 1'b0);
        one1("neg", 9'h1FF, 9'd2, 1'b0, -18, 1'b0);
        one1("relu", 9'h1FF, 9'd2, 1'b1, 0, 1'b0);
        one1("satp", 9'd255, 9'd255, 1'b0, 255, 1'b1);
        one1("satn", 9'h100, 9'd255, 1'b0, -256, 1'b1);

        grp4("g90", 9'd1, 4'b0000, 22);
        grp4("gfloor", 9'h1FF, 4'b0111, -23);
        grp4("grelu", 9'h1FF, 4'b1000, 0);

        // eight streamed beats: outputs after edges 5 and 9
        for (int i = 0; i < 12; i++) begin
            w = 9'((i % 4) + 1);
            b_iv = (i < 8); b_act = {9{9'd1}}; b_wgt = {9{w}};
            tick();
            chk("stream_v", 32'(b_ov), (i == 5 || i == 9) ? 1 : 0);
            if (i == 5 || i == 9) chk("stream_d", b_data, 22);
        end

        // backpressure: group 1 (wgt 1..4) then group 2 (wgt all 2, total 72 -> 18)
        b_or = 1'b0;
        for (int i = 0; i < 6; i++) begin
            w = (i < 4) ? 9'(i + 1) : 9'd2;
            b_iv = 1'b1; b_act = {9{9'd1}}; b_wgt = {9{w}};
            tick();
        end
        chk("bp_ov", 32'(b_ov), 1);
        chk("bp_data", b_data, 22);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_ir", 32'(b_ir), 0);
            chk("bp_hold_v", 32'(b_ov), 1);
            chk("bp_hold_d", b_data, 22);
        end
        b_or = 1'b1;
        tick();
        chk("bp_rel", 32'(b_ov), 0);
        tick();
        b_iv = 1'b0;
        chk("bp_e10", 32'(b_ov), 0);
        tick();
        chk("bp_e11", 32'(b_ov), 0);
        tick();
        chk("bp_out_v", 32'(b_ov), 1);
        chk("bp_out_d", b_data, 18);
        tick();
        chk("bp_pulse", 32'(b_ov), 0);

        // reset mid-accumulation with a pending output on the CH=1 instance
        a_or = 1'b0;
        a_iv = 1'b1; a_act = {9{9'd1}}; a_wgt = {9{9'd2}};
        for (int i = 0; i < 2; i++) begin
            b_iv = 1'b1; b_act = {9{9'd1}}; b_wgt = {9{9'd4}};
            tick();
            a_iv = 1'b0;
        end
        b_iv = 1'b0;
        tick();
        chk("pend_ov", 32'(a_ov), 1);
        rst = 1'b1;
        #1;
        chk("async_ov", 32'(a_ov), 0);
        chk("async_data", a_data, 0);
        #1;
        rst = 1'b0;
        a_or = 1'b1;
        grp4("after_rst", 9'd1, 4'b0000, 22);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
